ecc_enc_40_33_arb: RTL and testbench
====================================

# ecc_enc_40_33_arb

Round-robin scheduler that shares one `ecc_enc_40_33` encoder (PINVERT=1) among `NUM_REQ` 33-bit requesters in the SL3 FEC TX path. It uses credit-based issue so the non-stallable encoder pipeline never overflows the output skid FIFO under downstream backpressure. Each encoded 40-bit word is tagged with the ID of its source requester. A halt/drain FSM lets link control freeze the encoder cleanly.

## Interface
Parameters:
- `TARGET_CHIP`, 0, passed to the encoder.
- `NUM_REQ`, 4, number of requesters (2..8).
- `ENC_LATENCY`, 1, encoder clk-to-dout latency in cycles; must match the instantiated encoder.
- `ID_W`, 2, requester ID width, ≥ clog2(NUM_REQ).

Ports:
- `clk`  in  1  the only clock.
- `sclr`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*33  requester i data is bits [33i+32:33i].
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when valid&&ready.
- `halt`  in  1  request to stop issuing and drain.
- `halted`  out  1  encoder idle and FIFO empty while halt is held.
- `out_valid`  out  1  encoded word available.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  40  encoded word.
- `out_id`  out  ID_W  source requester of `out_data`.
- `disp_err`  out  1  sticky disparity violation (see Configuration).

## Operation
- Skid FIFO: depth D = ENC_LATENCY+2 entries of {id, 40-bit word}, show-ahead.
- Credit counter: reset value D.
  - Decrements on a grant and increments on a pop (out_valid&&out_ready).
  - Both in the same cycle: unchanged.
  - Never exceeds D and never goes below 0.
- Grant rule: at most one grant per cycle, only when credits>0 and the FSM is RUN.
  - Winner is the first requester with req_valid=1, searching from `rr_ptr` upward with wrap.
  - `req_ready` is combinational from req_valid, rr_ptr, credits and state. It never depends on req_data.
- `rr_ptr` (reset 0): after a grant to requester i, becomes (i+1) mod NUM_REQ. Unchanged with no grant.
- Tag pipeline: a {valid, id} shift register ENC_LATENCY deep runs alongside the encoder. The tag valid at the pipe tail writes the encoder dout and id into the FIFO.
- FSM (reset RUN):
  - RUN: halt=1 → DRAIN.
  - DRAIN: no grants. Tag pipe empty and FIFO empty → HALTED. halt=0 → RUN.
  - HALTED: `halted`=1, no grants. halt=0 → RUN.
- Words already in flight when halt rises are always delivered, never dropped.
- sclr mid-operation: clears FIFO, tag pipe, credits (to D), rr_ptr and FSM. In-flight words are discarded.

## Timing
- Reset values: req_ready=0, out_valid=0, out_data=0, out_id=0, halted=0, disp_err=0.
- Latency: a word accepted at edge t presents out_valid at edge t+ENC_LATENCY+1.
- Throughput: 1 word/cycle sustained with out_ready=1. D credits cover the grant→pop→credit round trip.
- out_ready=0:
  - At most D words are issued, then req_ready stays 0.
  - out_valid/out_data/out_id hold stable until the pop.
- Full FIFO with pending requests: no grant. The first grant comes in the cycle after the credit-returning pop edge.
- halt rising at edge t: no grant in the cycle following t.
- `halted` rises in the cycle after the last pop has drained.

## Configuration
- `ECC_ENC_ARB_DISP_CHK_EN` defined:
  - Each popped word has its ones count computed (registered, 1 cycle after pop).
  - Count <3 or >37 sets `disp_err`. It stays set until sclr.
- Not defined: no checker logic; `disp_err` is tied 0. Port list is unchanged.

## Test plan
- Reset/idle: sclr 3 cycles, all req_valid=0 → all outputs 0, credits=D, FSM RUN, no out_valid for 20 cycles.
- Fairness: NUM_REQ=4, all four valid continuously, out_ready=1 → out_id sequence 0,1,2,3,0,1… with one word per cycle. Each out_data equals a reference encoding of that requester's data.
- Backpressure: out_ready=0, all valid → exactly D=3 grants (ENC_LATENCY=1). Then req_ready=0 and out_data is stable. out_ready=1 → words drain in order and grants resume one cycle after the first pop.
- Halt drain: issue 2 words, assert halt in the same cycle as the second grant → both words are delivered, then halted=1. Deasserting halt → next grant in the following cycle.
- Reset mid-stream: sclr while 2 words are in flight → no out_valid afterward, credits back to D, first post-reset grant goes to requester 0.
- Disparity (macro on): 33'h1FFFFFFFF and 33'h0 plus single-bit walking patterns → disp_err stays 0. Force an injected encoder output with 38 ones → disp_err=1 and it holds until sclr.

Source files
------------

// File: rtl/ecc_enc_40_33_arb.sv
// Credit-gated round-robin front end sharing one (40,33) SECDED encoder among NUM_REQ requesters.
// Optional popped-word disparity checker is built when ECC_ENC_ARB_DISP_CHK_EN is defined.

module ecc_enc_40_33 #(
  parameter int TARGET_CHIP = 0,
  parameter int PINVERT     = 1,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic [32:0] din,
  output logic [39:0] dout
);

  // Hamming over codeword positions 1..39 (data skips powers of two) plus overall parity
  function automatic logic [39:0] enc_word(input logic [32:0] d);
    logic [5:0] chk;
    logic       ovr;
    int         j;
    chk = 6'd0;
    j   = 0;
    for (int p = 1; p < 40; p++) begin
      if ((p & (p - 1)) != 0) begin
        chk = d[j] ? (chk ^ 6'(p)) : chk;
        j   = j + 1;
      end else begin
        j   = j;
      end
    end
    ovr = (^d) ^ (^chk);
    return (PINVERT != 0) ? {~ovr, ~chk, d} : {ovr, chk, d};
  endfunction

  logic [39:0] pipe_r [LATENCY];

  generate
    if (TARGET_CHIP == 0) begin : g_rst
      // Encode pipeline, cleared by sclr
      always_ff @(posedge clk) begin
        if (sclr) begin
          for (int k = 0; k < LATENCY; k++) pipe_r[k] <= 40'd0;
        end else begin
          pipe_r[0] <= enc_word(din);
          for (int k = 1; k < LATENCY; k++) pipe_r[k] <= pipe_r[k-1];
        end
      end
    end else begin : g_norst
      // Encode pipeline without reset; the tag pipe qualifies every stage
      always_ff @(posedge clk) begin
        pipe_r[0] <= enc_word(din);
        for (int k = 1; k < LATENCY; k++) pipe_r[k] <= pipe_r[k-1];
      end
    end
  endgenerate

  assign dout = pipe_r[LATENCY-1];

endmodule

module ecc_enc_40_33_arb #(
  parameter int TARGET_CHIP = 0,
  parameter int NUM_REQ     = 4,
  parameter int ENC_LATENCY = 1,
  parameter int ID_W        = 2
) (
  input  logic                 clk,
  input  logic                 sclr,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*33-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 halt,
  output logic                 halted,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [39:0]          out_data,
  output logic [ID_W-1:0]      out_id,
  output logic                 disp_err
);

  localparam int D  = ENC_LATENCY + 2;
  localparam int CW = $clog2(D + 1);
  localparam int PW = $clog2(D);
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]   PTR_LAST = PW'(D - 1);
  localparam logic [CW-1:0]   CRED_MAX = CW'(D);
  localparam logic [ID_W-1:0] ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_HALTED = 2'd2} state_t;

  state_t             state_r;
  logic               halted_r;
  logic [CW-1:0]      credits_r;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ENC_LATENCY-1:0] tag_vld_r;
  logic [ID_W-1:0]    tag_id_r [ENC_LATENCY];
  logic [39:0]        fifo_data_r [D];
  logic [ID_W-1:0]    fifo_id_r [D];
  logic [PW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]      count_r;

  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_id_s;
  logic               grant_any_s, can_grant_s, found_s, hit_s, push_s, pop_s, idle_s;
  int                 idx_s;
  logic [SW-1:0]      sel_s;
  logic [32:0]        enc_din_s;
  logic [39:0]        enc_dout_s;

  // Round-robin search from rr_ptr, qualified by credits and RUN state only
  always_comb begin
    grant_s     = '0;
    grant_id_s  = '0;
    found_s     = 1'b0;
    hit_s       = 1'b0;
    idx_s       = 0;
    sel_s       = '0;
    can_grant_s = !sclr && (state_r == ST_RUN) && (credits_r != '0);
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s          = int'(rr_ptr_r) + k;
      idx_s          = (idx_s >= NUM_REQ) ? (idx_s - NUM_REQ) : idx_s;
      sel_s          = SW'(idx_s);
      hit_s          = can_grant_s && !found_s && req_valid[sel_s];
      grant_s[sel_s] = grant_s[sel_s] | hit_s;
      grant_id_s     = hit_s ? ID_W'(idx_s) : grant_id_s;
      found_s        = found_s | hit_s;
    end
    grant_any_s = found_s;
  end

  assign req_ready = grant_s;
  assign enc_din_s = req_data[33*int'(grant_id_s) +: 33];
  assign push_s    = tag_vld_r[ENC_LATENCY-1];
  assign out_valid = (count_r != '0);
  assign pop_s     = out_valid && out_ready;
  assign out_data  = fifo_data_r[rd_ptr_r];
  assign out_id    = fifo_id_r[rd_ptr_r];
  assign halted    = halted_r;
  assign idle_s    = (tag_vld_r == '0) && (count_r == '0);

  ecc_enc_40_33 #(
    .TARGET_CHIP (TARGET_CHIP),
    .PINVERT     (1),
    .LATENCY     (ENC_LATENCY)
  ) u_enc (
    .clk  (clk),
    .sclr (sclr),
    .din  (enc_din_s),
    .dout (enc_dout_s)
  );

  // Credits, rr pointer, tag pipe and skid FIFO; credits bound FIFO occupancy plus in-flight words
  always_ff @(posedge clk) begin
    if (sclr) begin
      credits_r <= CRED_MAX;
      rr_ptr_r  <= '0;
      tag_vld_r <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      for (int k = 0; k < ENC_LATENCY; k++) tag_id_r[k] <= '0;
      for (int k = 0; k < D; k++) begin
        fifo_data_r[k] <= 40'd0;
        fifo_id_r[k]   <= '0;
      end
    end else begin
      case ({grant_any_s, pop_s})
        2'b10:   credits_r <= credits_r - CW'(1);
        2'b01:   credits_r <= credits_r + CW'(1);
        default: credits_r <= credits_r;
      endcase
      if (grant_any_s) begin
        rr_ptr_r <= (grant_id_s == ID_LAST) ? '0 : (grant_id_s + ID_W'(1));
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      for (int k = ENC_LATENCY - 1; k > 0; k--) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_id_r[k]  <= tag_id_r[k-1];
      end
      tag_vld_r[0] <= grant_any_s;
      tag_id_r[0]  <= grant_id_s;
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= enc_dout_s;
        fifo_id_r[wr_ptr_r]   <= tag_id_r[ENC_LATENCY-1];
        wr_ptr_r              <= (wr_ptr_r == PTR_LAST) ? '0 : (wr_ptr_r + PW'(1));
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : (rd_ptr_r + PW'(1));
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Halt/drain FSM; halted asserted only once nothing is in flight
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          state_r  <= halt ? ST_DRAIN : ST_RUN;
          halted_r <= 1'b0;
        end
        ST_DRAIN: begin
          if (!halt) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
          end else if (idle_s) begin
            state_r  <= ST_HALTED;
            halted_r <= 1'b1;
          end else begin
            state_r  <= ST_DRAIN;
            halted_r <= 1'b0;
          end
        end
        ST_HALTED: begin
          state_r  <= halt ? ST_HALTED : ST_RUN;
          halted_r <= halt;
        end
        default: begin
          state_r  <= ST_RUN;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef ECC_ENC_ARB_DISP_CHK_EN
  function automatic logic [5:0] ones40(input logic [39:0] w);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < 40; i++) cnt = cnt + 6'(w[i]);
    return cnt;
  endfunction

  logic [5:0] ones_r;
  logic       ones_vld_r;
  logic       disp_err_r;

  // Ones count of each popped word, then sticky range check one cycle later
  always_ff @(posedge clk) begin
    if (sclr) begin
      ones_r     <= 6'd0;
      ones_vld_r <= 1'b0;
      disp_err_r <= 1'b0;
    end else begin
      ones_vld_r <= pop_s;
      ones_r     <= pop_s ? ones40(out_data) : ones_r;
      disp_err_r <= disp_err_r | (ones_vld_r && ((ones_r < 6'd3) || (ones_r > 6'd37)));
    end
  end

  assign disp_err = disp_err_r;
`else
  assign disp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_enc_40_33_arb.sv
// Directed self-checking bench for ecc_enc_40_33_arb (NUM_REQ=4, ENC_LATENCY=1, D=3).
// Disparity injection scenario is compiled when ECC_ENC_ARB_DISP_CHK_EN is defined.

module tb_ecc_enc_40_33_arb;

  logic          clk = 1'b0;
  logic          sclr;
  logic [3:0]    req_valid;
  logic [131:0]  req_data;
  logic [3:0]    req_ready;
  logic          halt;
  logic          halted;
  logic          out_valid;
  logic          out_ready;
  logic [39:0]   out_data;
  logic [1:0]    out_id;
  logic          disp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          gnt_id_q[$];
  int          gnt_cyc_q[$];
  int          pop_id_q[$];
  int          pop_cyc_q[$];
  logic [39:0] pop_data_q[$];
  logic [39:0] exp_word [4];

  ecc_enc_40_33_arb #(
    .TARGET_CHIP (0),
    .NUM_REQ     (4),
    .ENC_LATENCY (1),
    .ID_W        (2)
  ) dut (
    .clk       (clk),
    .sclr      (sclr),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .halt      (halt),
    .halted    (halted),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .disp_err  (disp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference SECDED: XOR the codeword positions of the set data bits, then invert the check bits
  function automatic logic [39:0] ref_enc(input logic [32:0] d);
    logic [5:0] syn;
    int         pos;
    syn = 6'd0;
    pos = 1;
    for (int i = 0; i < 33; i++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      if (d[i]) syn = syn ^ pos[5:0];
      pos++;
    end
    return {~((^d) ^ (^syn)), ~syn, d};
  endfunction

  always @(posedge clk) begin
    if (!sclr) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          gnt_id_q.push_back(i);
          gnt_cyc_q.push_back(cyc);
        end
      end
      if (out_valid && out_ready) begin
        pop_id_q.push_back(int'(out_id));
        pop_data_q.push_back(out_data);
        pop_cyc_q.push_back(cyc);
      end
    end
    cyc <= cyc + 1;
  end

  task automatic clear_q();
    gnt_id_q.delete();
    gnt_cyc_q.delete();
    pop_id_q.delete();
    pop_data_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    sclr      = 1'b1;
    req_valid = 4'b0000;
    halt      = 1'b0;
    repeat (2) @(negedge clk);
    sclr = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    int seen;
    sclr      = 1'b1;
    req_valid = 4'b0000;
    halt      = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 40'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_out_id: got %0d want 0", out_id); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (disp_err !== 1'b0) begin n_fail++; $display("FAIL reset_disp_err: got %b want 0", disp_err); end
    sclr = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || req_ready !== 4'b0000) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_fairness();
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (12) @(negedge clk);
    req_valid = 4'b0000;
    repeat (6) @(negedge clk);
    n_checks++; if (pop_id_q.size() != 12) begin n_fail++; $display("FAIL fair_count: got %0d want 12", pop_id_q.size()); end
    for (int k = 0; k < pop_id_q.size() && k < 12; k++) begin
      n_checks++; if (pop_id_q[k] != k % 4) begin n_fail++; $display("FAIL fair_id[%0d]: got %0d want %0d", k, pop_id_q[k], k % 4); end
      n_checks++; if (pop_data_q[k] !== exp_word[k % 4]) begin n_fail++; $display("FAIL fair_data[%0d]: got %h want %h", k, pop_data_q[k], exp_word[k % 4]); end
      n_checks++; if (pop_cyc_q[k] != pop_cyc_q[0] + k) begin n_fail++; $display("FAIL fair_rate[%0d]: got cycle %0d want %0d", k, pop_cyc_q[k], pop_cyc_q[0] + k); end
    end
    if (gnt_cyc_q.size() > 0 && pop_cyc_q.size() > 0) begin
      n_checks++; if (pop_cyc_q[0] != gnt_cyc_q[0] + 2) begin n_fail++; $display("FAIL fair_latency: got %0d cycles want 2", pop_cyc_q[0] - gnt_cyc_q[0]); end
    end else begin
      n_checks++; n_fail++; $display("FAIL fair_latency: got no traffic want grant and pop");
    end
  endtask

  task automatic test_backpressure();
    int expect_ids [5];
    expect_ids = '{0, 1, 2, 3, 0};
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (8) @(negedge clk);
    n_checks++; if (gnt_id_q.size() != 3) begin n_fail++; $display("FAIL bp_grants: got %0d want 3", gnt_id_q.size()); end
    for (int k = 0; k < gnt_id_q.size() && k < 3; k++) begin
      n_checks++; if (gnt_id_q[k] != k) begin n_fail++; $display("FAIL bp_grant_id[%0d]: got %0d want %0d", k, gnt_id_q[k], k); end
    end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0000", req_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== exp_word[0]) begin n_fail++; $display("FAIL bp_head: got v=%b id=%0d %h want v=1 id=0 %h", out_valid, out_id, out_data, exp_word[0]); end
    repeat (3) @(negedge clk);
    n_checks++; if (out_id !== 2'd0 || out_data !== exp_word[0]) begin n_fail++; $display("FAIL bp_hold: got id=%0d %h want id=0 %h", out_id, out_data, exp_word[0]); end
    clear_q();
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    req_valid = 4'b0000;
    repeat (8) @(negedge clk);
    if (gnt_cyc_q.size() > 0 && pop_cyc_q.size() > 0) begin
      n_checks++; if (gnt_cyc_q[0] != pop_cyc_q[0] + 1) begin n_fail++; $display("FAIL bp_resume: got grant %0d cycles after pop want 1", gnt_cyc_q[0] - pop_cyc_q[0]); end
    end else begin
      n_checks++; n_fail++; $display("FAIL bp_resume: got no traffic want grant and pop");
    end
    n_checks++; if (pop_id_q.size() < 5) begin n_fail++; $display("FAIL bp_drain_count: got %0d want >=5", pop_id_q.size()); end
    for (int k = 0; k < pop_id_q.size() && k < 5; k++) begin
      n_checks++; if (pop_id_q[k] != expect_ids[k] || pop_data_q[k] !== exp_word[expect_ids[k]]) begin n_fail++; $display("FAIL bp_order[%0d]: got id=%0d %h want id=%0d %h", k, pop_id_q[k], pop_data_q[k], expect_ids[k], exp_word[expect_ids[k]]); end
    end
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL halt_no_grant: got %b want 0000", req_ready); end
    for (int i = 0; i < 20 && halted !== 1'b1; i++) @(negedge clk);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted: got %b want 1", halted); end
    n_checks++; if (pop_id_q.size() != 2) begin n_fail++; $display("FAIL halt_delivered: got %0d want 2", pop_id_q.size()); end
    for (int k = 0; k < pop_id_q.size() && k < 2; k++) begin
      n_checks++; if (pop_id_q[k] != 0 || pop_data_q[k] !== exp_word[0]) begin n_fail++; $display("FAIL halt_word[%0d]: got id=%0d %h want id=0 %h", k, pop_id_q[k], pop_data_q[k], exp_word[0]); end
    end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL halt_idle_ready: got %b want 0000", req_ready); end
    halt = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL unhalt_same_cycle: got %b want 0000", req_ready); end
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001 || halted !== 1'b0) begin n_fail++; $display("FAIL unhalt_grant: got ready=%b halted=%b want 0001/0", req_ready, halted); end
    req_valid = 4'b0000;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    int seen;
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b0110;
    repeat (2) @(negedge clk);
    req_valid = 4'b0000;
    n_checks++; if (gnt_id_q.size() != 2) begin n_fail++; $display("FAIL mid_pre_grants: got %0d want 2", gnt_id_q.size()); end
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    clear_q();
    out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0 || pop_id_q.size() != 0) begin n_fail++; $display("FAIL mid_discard: got %0d valid cycles %0d pops want 0", seen, pop_id_q.size()); end
    out_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    repeat (6) @(negedge clk);
    n_checks++; if (gnt_id_q.size() != 3) begin n_fail++; $display("FAIL mid_credits: got %0d grants want 3", gnt_id_q.size()); end
    req_valid = 4'b0000;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_disparity();
`ifdef ECC_ENC_ARB_DISP_CHK_EN
    logic [32:0] one33;
    logic [32:0] sent [35];
    one33 = 33'h1;
    do_reset();
    out_ready = 1'b1;
    for (int b = 0; b < 35; b++) begin
      sent[b] = (b < 33) ? (one33 << b) : ((b == 33) ? 33'h0 : 33'h1FFFFFFFF);
      req_data[32:0] = sent[b];
      req_valid = 4'b0001;
      @(negedge clk);
    end
    req_valid = 4'b0000;
    req_data[32:0] = 33'h0;
    repeat (6) @(negedge clk);
    n_checks++; if (pop_data_q.size() != 35) begin n_fail++; $display("FAIL disp_count: got %0d want 35", pop_data_q.size()); end
    for (int k = 0; k < pop_data_q.size() && k < 35; k++) begin
      n_checks++; if (pop_data_q[k] !== ref_enc(sent[k])) begin n_fail++; $display("FAIL disp_word[%0d]: got %h want %h", k, pop_data_q[k], ref_enc(sent[k])); end
    end
    n_checks++; if (disp_err !== 1'b0) begin n_fail++; $display("FAIL disp_clean: got %b want 0", disp_err); end
    force dut.enc_dout_s = 40'hFFFFFFFFFC;
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (6) @(negedge clk);
    release dut.enc_dout_s;
    n_checks++; if (disp_err !== 1'b1) begin n_fail++; $display("FAIL disp_inject: got %b want 1", disp_err); end
    repeat (5) @(negedge clk);
    n_checks++; if (disp_err !== 1'b1) begin n_fail++; $display("FAIL disp_sticky: got %b want 1", disp_err); end
    do_reset();
    n_checks++; if (disp_err !== 1'b0) begin n_fail++; $display("FAIL disp_sclr: got %b want 0", disp_err); end
`else
    n_checks++; if (disp_err !== 1'b0) begin n_fail++; $display("FAIL disp_tied: got %b want 0", disp_err); end
`endif
  endtask

  initial begin
    sclr      = 1'b1;
    req_valid = 4'b0000;
    halt      = 1'b0;
    out_ready = 1'b0;
    req_data  = {33'h0DEADBEEF, 33'h1FFFFFFFF, 33'h000000001, 33'h000000000};
    exp_word[0] = 40'hFE00000000;
    exp_word[1] = 40'h7800000001;
    exp_word[2] = 40'h01FFFFFFFF;
    exp_word[3] = ref_enc(33'h0DEADBEEF);
    test_reset();
    test_fairness();
    test_backpressure();
    test_halt();
    test_reset_midstream();
    test_disparity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
